// File: rtl/net_strength_pkg.sv
// Shared types for the net strength arbiter.
//   strength_t  : Verilog-style drive strength, ascending order (HIGHZ weakest).
//   net_state_t : resolver state (IDLE, OWNED, CONFLICT).
//   str_max     : two-input strength maximum used by the reduction tree.
package net_strength_pkg;

  typedef enum logic [2:0] {
    ST_HIGHZ  = 3'd0,
    ST_SMALL  = 3'd1,
    ST_MEDIUM = 3'd2,
    ST_WEAK   = 3'd3,
    ST_LARGE  = 3'd4,
    ST_PULL   = 3'd5,
    ST_STRONG = 3'd6,
    ST_SUPPLY = 3'd7
  } strength_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWNED    = 2'd1,
    CONFLICT = 2'd2
  } net_state_t;

  function automatic strength_t str_max(input strength_t a, input strength_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/net_strength_arbiter_max_tree.sv
// strength_max_tree: combinational log-depth maximum over the active drivers.
// Ports:
//   act_i  [N_REQ]    requester is active (req and non-HIGHZ strength)
//   val_i  [N_REQ]    value driven by each requester
//   str_i  [3*N_REQ]  packed per-requester strengths
//   smax_o [3]        strongest active strength (HIGHZ when nobody is active)
//   w0_o   [N_REQ]    winners (active, at smax) driving 0
//   w1_o   [N_REQ]    winners (active, at smax) driving 1
module strength_max_tree
  import net_strength_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   act_i,
  input  logic [N_REQ-1:0]   val_i,
  input  logic [3*N_REQ-1:0] str_i,
  output logic [2:0]         smax_o,
  output logic [N_REQ-1:0]   w0_o,
  output logic [N_REQ-1:0]   w1_o
);

  // The tree is a heap padded up to a power of two: leaves live at
  // [P .. 2P-1], node k combines children 2k and 2k+1, root is node 1.
  localparam int P = 1 << $clog2(N_REQ);

  logic [P-1:0]   act_pad;
  logic [3*P-1:0] str_pad;
  strength_t      tree_node [1:2*P-1];
  strength_t      smax;

  always_comb begin
    act_pad = P'(act_i);
    str_pad = (3*P)'(str_i);
    // Inactive and padding leaves contribute HIGHZ, the identity of max.
    for (int k = 0; k < P; k++) begin
      tree_node[P+k] = act_pad[k] ? strength_t'(str_pad[3*k +: 3]) : ST_HIGHZ;
    end
    for (int k = P - 1; k >= 1; k--) begin
      tree_node[k] = str_max(tree_node[2*k], tree_node[2*k+1]);
    end
    smax = tree_node[1];
  end

  always_comb begin
    w0_o = '0;
    w1_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (act_i[i] && (str_i[3*i +: 3] == smax)) begin
        w0_o[i] = ~val_i[i];
        w1_o[i] =  val_i[i];
      end
    end
  end

  assign smax_o = smax;

endmodule

// File: rtl/net_strength_arbiter.sv
// net_strength_arbiter: resolves one shared single-bit net driven by N_REQ
// requesters with Verilog drive strengths. The strongest active level wins;
// equal-strength disagreement resolves to X. All outputs are registered and
// follow the sampled inputs by one cycle.
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   req [N_REQ]   drive request per requester
//   val [N_REQ]   driven value per requester
//   str [3*N_REQ] strength per requester (strength_t)
//   gnt [N_REQ]   one-hot owner, zero in IDLE and CONFLICT
//   net_val       resolved value (valid when net_z=0 and net_x=0)
//   net_z         no active driver
//   net_x         equal-strength drivers disagree
//   own_str [3]   strength of the winning level
//   conflict_cnt  saturating count of entries into CONFLICT
//   state_dbg [2] current resolver state (net_state_t encoding)
module net_strength_arbiter
  import net_strength_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   val,
  input  logic [3*N_REQ-1:0] str,
  output logic [N_REQ-1:0]   gnt,
  output logic               net_val,
  output logic               net_z,
  output logic               net_x,
  output logic [2:0]         own_str,
  output logic [CNT_W-1:0]   conflict_cnt,
  output logic [1:0]         state_dbg
);

  localparam int RR_W = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_OWNED    = OWNED;
  localparam logic [1:0] S_CONFLICT = CONFLICT;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q,   state_d;
  logic [N_REQ-1:0] gnt_q,     gnt_d;
  logic             net_val_q, net_val_d;
  logic             net_z_q,   net_z_d;
  logic             net_x_q,   net_x_d;
  logic [2:0]       own_str_q, own_str_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [RR_W-1:0]  rr_q,      rr_d;

  logic [N_REQ-1:0] active;
  logic [N_REQ-1:0] w0, w1, w_mask;
  logic [2:0]       smax;
  logic [RR_W-1:0]  pick_idx;
  logic             pick_found;
  logic             owner_kept;

  always_comb begin
    active = '0;
    for (int i = 0; i < N_REQ; i++) begin
      active[i] = req[i] && (str[3*i +: 3] != ST_HIGHZ);
    end
  end

  strength_max_tree #(
    .N_REQ (N_REQ)
  ) u_max_tree (
    .act_i  (active),
    .val_i  (val),
    .str_i  (str),
    .smax_o (smax),
    .w0_o   (w0),
    .w1_o   (w1)
  );

  assign w_mask = w0 | w1;

  // Round-robin search: first winner at or after rr_q, wrapping.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_found && w_mask[idx]) begin
        pick_found = 1'b1;
        pick_idx   = RR_W'(idx);
      end
    end
  end

  // The current owner keeps the grant only while it is still among the
  // winners; a strictly stronger newcomer empties that intersection.
  assign owner_kept = (state_q == S_OWNED) && (|(gnt_q & w_mask));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    net_val_d = net_val_q;
    net_z_d   = net_z_q;
    net_x_d   = net_x_q;
    own_str_d = own_str_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;

    if (smax == ST_HIGHZ) begin
      // Nobody drives: net floats, last value is retained.
      state_d   = S_IDLE;
      gnt_d     = '0;
      net_z_d   = 1'b1;
      net_x_d   = 1'b0;
      own_str_d = '0;
    end else if ((|w0) && (|w1)) begin
      state_d   = S_CONFLICT;
      gnt_d     = '0;
      net_z_d   = 1'b0;
      net_x_d   = 1'b1;
      own_str_d = smax;
      // Count entries only, so a long conflict is a single event.
      if ((state_q != S_CONFLICT) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      state_d   = S_OWNED;
      net_z_d   = 1'b0;
      net_x_d   = 1'b0;
      own_str_d = smax;
      net_val_d = |w1;
      if (!owner_kept && pick_found) begin
        gnt_d           = '0;
        gnt_d[pick_idx] = 1'b1;
        rr_d = (pick_idx == RR_W'(N_REQ - 1)) ? '0 : pick_idx + RR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      net_val_q <= 1'b0;
      net_z_q   <= 1'b1;
      net_x_q   <= 1'b0;
      own_str_q <= '0;
      cnt_q     <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      net_val_q <= net_val_d;
      net_z_q   <= net_z_d;
      net_x_q   <= net_x_d;
      own_str_q <= own_str_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
    end
  end

  assign gnt          = gnt_q;
  assign net_val      = net_val_q;
  assign net_z        = net_z_q;
  assign net_x        = net_x_q;
  assign own_str      = own_str_q;
  assign conflict_cnt = cnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_net_strength_arbiter.sv
module tb_net_strength_arbiter;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int VW = N + 1 + 1 + 1 + 3 + CW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req = '0;
  logic [N-1:0]   val = '0;
  logic [3*N-1:0] str = '0;
  logic [N-1:0]   gnt;
  logic           net_val, net_z, net_x;
  logic [2:0]     own_str;
  logic [CW-1:0]  conflict_cnt;
  logic [1:0]     state_dbg;

  net_strength_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .val          (val),
    .str          (str),
    .gnt          (gnt),
    .net_val      (net_val),
    .net_z        (net_z),
    .net_x        (net_x),
    .own_str      (own_str),
    .conflict_cnt (conflict_cnt),
    .state_dbg    (state_dbg)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  // state: 0 idle, 1 owned, 2 conflict; owner -1 means no owner.
  int   m_state, m_owner, m_rr, m_cnt, m_str;
  logic m_val;

  task automatic model_reset();
    m_state = 0; m_owner = -1; m_rr = 0; m_cnt = 0; m_str = 0; m_val = 1'b0;
  endtask

  task automatic model_step();
    int smax, n0, n1, s;
    bit win [N];
    smax = 0;
    for (int i = 0; i < N; i++) begin
      s = int'(str[3*i +: 3]);
      if (req[i] && s != 0 && s > smax) smax = s;
    end
    n0 = 0; n1 = 0;
    for (int i = 0; i < N; i++) begin
      win[i] = req[i] && (smax != 0) && (int'(str[3*i +: 3]) == smax);
      if (win[i] && val[i] == 1'b0) n0++;
      if (win[i] && val[i] == 1'b1) n1++;
    end
    if (smax == 0) begin
      m_state = 0; m_owner = -1; m_str = 0;
    end else if (n0 > 0 && n1 > 0) begin
      if (m_state != 2 && m_cnt < 255) m_cnt++;
      m_state = 2; m_owner = -1; m_str = smax;
    end else begin
      if (!(m_state == 1 && win[m_owner])) begin
        for (int k = 0; k < N; k++) begin
          if (win[(m_rr + k) % N]) begin
            m_owner = (m_rr + k) % N;
            break;
          end
        end
        m_rr = (m_owner + 1) % N;
      end
      m_state = 1; m_str = smax; m_val = (n1 > 0);
    end
  endtask

  function automatic logic [VW-1:0] observed();
    return {gnt, net_val, net_z, net_x, own_str, conflict_cnt, state_dbg};
  endfunction

  function automatic logic [VW-1:0] expected();
    logic [N-1:0] g;
    g = '0;
    if (m_state == 1) g[m_owner] = 1'b1;
    return {g, m_val, (m_state == 0), (m_state == 2), m_str[2:0], m_cnt[CW-1:0], m_state[1:0]};
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_all();
    req = '0; val = '0; str = '0;
  endtask

  task automatic set_drv(input int i, input bit r, input bit v, input int s);
    req[i] = r;
    val[i] = v;
    str[3*i +: 3] = s[2:0];
  endtask

  task automatic do_reset();
    clear_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Advance one clock, update the model with the sampled inputs, settle.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tests_run++;
    if (net_z !== 1'b1 || gnt !== '0 || conflict_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: net_z=%b gnt=%b cnt=%0d, want 1 0000 0", net_z, gnt, conflict_cnt);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      tests_run++;
      if (net_z !== 1'b1 || observed() !== expected()) begin
        tests_failed++;
        $display("FAIL reset_idle_hold c%0d: got %h want %h", c, observed(), expected());
      end
    end
  endtask

  task automatic test_priority();
    set_drv(0, 1, 1, 6);
    set_drv(1, 1, 0, 3);
    set_drv(2, 1, 0, 5);
    step();
    tests_run++;
    if (gnt !== 4'b0001 || net_val !== 1'b1 || own_str !== 3'd6 || net_x !== 1'b0 ||
        observed() !== expected()) begin
      tests_failed++;
      $display("FAIL priority: gnt=%b val=%b str=%0d x=%b, want 0001 1 6 0", gnt, net_val, own_str, net_x);
    end
  endtask

  task automatic test_conflict();
    clear_all();
    set_drv(1, 1, 0, 5);
    set_drv(2, 1, 1, 5);
    step();
    tests_run++;
    if (net_x !== 1'b1 || gnt !== '0 || conflict_cnt !== 8'd1 || observed() !== expected()) begin
      tests_failed++;
      $display("FAIL conflict_enter: x=%b gnt=%b cnt=%0d, want 1 0000 1", net_x, gnt, conflict_cnt);
    end
    step();
    tests_run++;
    if (conflict_cnt !== 8'd1 || observed() !== expected()) begin
      tests_failed++;
      $display("FAIL conflict_stay: cnt=%0d want 1", conflict_cnt);
    end
    set_drv(2, 0, 1, 5);
    step();
    tests_run++;
    if (gnt !== 4'b0010 || net_val !== 1'b0 || net_x !== 1'b0 || observed() !== expected()) begin
      tests_failed++;
      $display("FAIL conflict_resolve: gnt=%b val=%b x=%b, want 0010 0 0", gnt, net_val, net_x);
    end
  endtask

  task automatic test_round_robin_sticky();
    do_reset();
    set_drv(0, 1, 1, 3);
    set_drv(3, 1, 1, 3);
    step();
    tests_run++;
    if (gnt !== 4'b0001 || observed() !== expected()) begin
      tests_failed++;
      $display("FAIL rr_first: gnt=%b want 0001", gnt);
    end
    set_drv(0, 0, 1, 3);
    step();
    tests_run++;
    if (gnt !== 4'b1000 || observed() !== expected()) begin
      tests_failed++;
      $display("FAIL rr_owner_drop: gnt=%b want 1000", gnt);
    end
    set_drv(0, 1, 1, 3);
    step();
    tests_run++;
    if (gnt !== 4'b1000 || observed() !== expected()) begin
      tests_failed++;
      $display("FAIL rr_sticky: gnt=%b want 1000", gnt);
    end
  endtask

  task automatic test_preempt();
    clear_all();
    set_drv(1, 1, 0, 2);
    step();
    tests_run++;
    if (gnt !== 4'b0010 || own_str !== 3'd2 || observed() !== expected()) begin
      tests_failed++;
      $display("FAIL preempt_setup: gnt=%b str=%0d want 0010 2", gnt, own_str);
    end
    set_drv(2, 1, 1, 7);
    step();
    tests_run++;
    if (gnt !== 4'b0100 || net_val !== 1'b1 || own_str !== 3'd7 || observed() !== expected()) begin
      tests_failed++;
      $display("FAIL preempt: gnt=%b val=%b str=%0d want 0100 1 7", gnt, net_val, own_str);
    end
    clear_all();
    step();
    tests_run++;
    if (net_z !== 1'b1 || net_val !== 1'b1 || observed() !== expected()) begin
      tests_failed++;
      $display("FAIL idle_hold_val: z=%b val=%b want 1 1", net_z, net_val);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      // Hold inputs half the time so stickiness and long conflicts occur.
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < N; i++) begin
          set_drv(i, ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(4, 6));
        end
      end
      step();
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL random c%0d: got %h want %h (req=%b val=%b str=%h)",
                 c, observed(), expected(), req, val, str);
      end
    end
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      clear_all();
      set_drv(1, 1, 0, 5);
      set_drv(2, 1, 1, 5);
      step();
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL sat_conflict c%0d: got %h want %h", c, observed(), expected());
      end
      set_drv(2, 0, 1, 5);
      step();
    end
    tests_run++;
    if (conflict_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL saturate: cnt=%0d want 255", conflict_cnt);
    end
    set_drv(2, 1, 1, 5);
    step();
    tests_run++;
    if (net_x !== 1'b1 || conflict_cnt !== 8'd255 || observed() !== expected()) begin
      tests_failed++;
      $display("FAIL sat_hold: x=%b cnt=%0d want 1 255", net_x, conflict_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (observed() !== {4'b0000, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 2'd0}) begin
      tests_failed++;
      $display("FAIL async_reset: got %h want %h", observed(), {4'b0000, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 2'd0});
    end
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_priority();
    test_conflict();
    test_round_robin_sticky();
    test_preempt();
    test_random();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
